ahb_lite_master: RTL and testbench

//  Single-transfer AHB-Lite initiator. Takes one local request (addr/write/wdata) on a valid/ready

---
 rtl/ahb_lite_master_if.sv | 72 +++++++
 rtl/ahb_lite_master.sv | 218 +++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_if.sv
// +------------------------------------------------------------------+
// | Module  : ahb_lite_master_if                                     |
// | Brief   : Local request/response and AHB-Lite master pin bundle. |
// |           Optional macro AHB_WSTRB_EN adds req_strb / hwstrb.    |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef AHB_ADDR_WIDTH
  `define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
  `define AHB_DATA_WIDTH 32
`endif

interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AHB_DATA_WIDTH
);
  // local request side
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [2:0]              req_size;
  logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef AHB_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic [DATA_WIDTH/8-1:0] hwstrb;
`endif
  // local response side
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_slave_error;
  logic                    resp_other_error;
  // AHB-Lite bus side
  logic [ADDR_WIDTH-1:0]   haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH-1:0]   hrdata;
  logic                    hready;
  logic                    hresp;

  // view of the initiator block
  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
`ifdef AHB_WSTRB_EN
    input  req_strb,
    output hwstrb,
`endif
    output req_ready, resp_valid, resp_rdata, resp_slave_error, resp_other_error,
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  // view of the requester / bus slave surrounding the initiator
  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata,
`ifdef AHB_WSTRB_EN
    output req_strb,
    input  hwstrb,
`endif
    input  req_ready, resp_valid, resp_rdata, resp_slave_error, resp_other_error,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_master.sv
// +------------------------------------------------------------------+
// | Module  : ahb_lite_master                                        |
// | Brief   : Single-transfer AHB-Lite initiator. Accepts one local  |
// |           request, issues one NONSEQ SINGLE transfer, returns a  |
// |           one-cycle response with slave/other error flags.       |
// |           Optional macro AHB_WSTRB_EN enables byte strobes.      |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef AHB_ADDR_WIDTH
  `define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
  `define AHB_DATA_WIDTH 32
`endif

module ahb_lite_master #(
  parameter int ADDR_WIDTH     = `AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `AHB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ahb_lite_master_if.master  bus
);

  localparam int       c_size_max = $clog2(DATA_WIDTH / 8);
  localparam int       c_cnt_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  w_req_ready;
  logic                  w_accept;
  logic [2:0]            w_align_mask;
  logic                  w_illegal;
  logic                  w_timeout;

  logic [ADDR_WIDTH-1:0] r_haddr;
  logic [1:0]            r_htrans;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_cnt_w-1:0]    r_wait_cnt;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_slave_err;
  logic                  r_other_err;
`ifdef AHB_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [DATA_WIDTH/8-1:0] r_hwstrb;
`endif

  assign w_req_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_timeout   = (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  // Low address bits that must be zero for the requested transfer size
  always_comb begin
    w_align_mask = 3'b000;
    case (bus.req_size)
      3'd1:    w_align_mask = 3'b001;
      3'd2:    w_align_mask = 3'b011;
      3'd3:    w_align_mask = 3'b111;
      default: w_align_mask = 3'b000;
    endcase
  end

  assign w_illegal = (bus.req_size > 3'(c_size_max)) |
                     (|(bus.req_addr[2:0] & w_align_mask));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; an illegal request never leaves IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_illegal) w_next = S_ADDR;
      S_ADDR: if (bus.hready) w_next = S_DATA;
      S_DATA: begin
        if (bus.hready)      w_next = S_IDLE;
        else if (bus.hresp)  w_next = S_ERR;
        else if (w_timeout)  w_next = S_IDLE;
      end
      S_ERR:  if (bus.hready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered bus outputs, capture registers, wait counter and response pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_haddr      <= '0;
      r_htrans     <= c_htrans_idle;
      r_hwrite     <= 1'b0;
      r_hsize      <= 3'd0;
      r_hwdata     <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_slave_err  <= 1'b0;
      r_other_err  <= 1'b0;
`ifdef AHB_WSTRB_EN
      r_strb       <= '0;
      r_hwstrb     <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_slave_err  <= 1'b0;
      r_other_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_resp_valid <= 1'b1;
              r_other_err  <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_htrans <= c_htrans_nonseq;
              r_haddr  <= bus.req_addr;
              r_hwrite <= bus.req_write;
              r_hsize  <= bus.req_size;
              r_wdata  <= bus.req_wdata;
`ifdef AHB_WSTRB_EN
              r_strb   <= bus.req_strb;
`endif
            end
          end
        end
        S_ADDR: begin
          // address phase completes: write data is driven for the data phase
          if (bus.hready) begin
            r_htrans   <= c_htrans_idle;
            r_hwdata   <= r_hwrite ? r_wdata : '0;
            r_wait_cnt <= '0;
`ifdef AHB_WSTRB_EN
            r_hwstrb   <= r_hwrite ? r_strb : '0;
`endif
          end
        end
        S_DATA: begin
          if (bus.hready) begin
            r_hwdata     <= '0;
            r_resp_valid <= 1'b1;
            // hready with hresp set is treated as the tail of an ERROR response
            if (bus.hresp) begin
              r_slave_err  <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_resp_rdata <= r_hwrite ? '0 : bus.hrdata;
            end
`ifdef AHB_WSTRB_EN
            r_hwstrb     <= '0;
`endif
          end else if (!bus.hresp) begin
            if (w_timeout) begin
              r_hwdata     <= '0;
              r_resp_valid <= 1'b1;
              r_other_err  <= 1'b1;
              r_resp_rdata <= '0;
`ifdef AHB_WSTRB_EN
              r_hwstrb     <= '0;
`endif
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
        end
        S_ERR: begin
          if (bus.hready) begin
            r_hwdata     <= '0;
            r_resp_valid <= 1'b1;
            r_slave_err  <= 1'b1;
            r_resp_rdata <= '0;
`ifdef AHB_WSTRB_EN
            r_hwstrb     <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready        = w_req_ready;
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_rdata       = r_resp_rdata;
  assign bus.resp_slave_error = r_slave_err;
  assign bus.resp_other_error = r_other_err;
  assign bus.haddr            = r_haddr;
  assign bus.htrans           = r_htrans;
  assign bus.hwrite           = r_hwrite;
  assign bus.hsize            = r_hsize;
  assign bus.hburst           = 3'b000;
  assign bus.hwdata           = r_hwdata;
`ifdef AHB_WSTRB_EN
  assign bus.hwstrb           = r_hwstrb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// +------------------------------------------------------------------+
// | Module  : tb_ahb_lite_master                                     |
// | Brief   : Table-driven bench for ahb_lite_master with a response |
// |           scoreboard and hand-written reset-in-flight sequence.  |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ahb_lite_master;

  localparam int c_timeout = 8;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          addr_waits;
    int          data_waits;
    int          kind;       // 0 normal, 1 slave error, 2 timeout
    logic        legal;
    logic [31:0] exp_rdata;
    logic        exp_slave;
    logic        exp_other;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        slave;
    logic        other;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  vec_t vecs[11];

  ahb_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_lite_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(c_timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Response monitor: every resp_valid pulse is matched against the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (bus.resp_valid === 1'b1) begin
      chk("resp_one_error_kind", 64'(bus.resp_slave_error & bus.resp_other_error), 64'd0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
        chk("resp_slave_error", 64'(bus.resp_slave_error), 64'(e.slave));
        chk("resp_other_error", 64'(bus.resp_other_error), 64'(e.other));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_hw;
    int n;
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_write = v.write;
    bus.req_size  = v.size;
    bus.req_wdata = v.wdata;
`ifdef AHB_WSTRB_EN
    bus.req_strb  = 4'hA;
`endif
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    sb.push_back('{v.exp_rdata, v.exp_slave, v.exp_other});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!v.legal) begin
      chk("illegal_no_nonseq", 64'(bus.htrans), 64'd0);
      return;
    end
    chk("htrans_nonseq", 64'(bus.htrans), 64'd2);
    chk("haddr", 64'(bus.haddr), 64'(v.addr));
    chk("hwrite", 64'(bus.hwrite), 64'(v.write));
    chk("hsize", 64'(bus.hsize), 64'(v.size));
    chk("hburst", 64'(bus.hburst), 64'd0);
    if (v.addr_waits > 0) begin
      bus.hready = 1'b0;
      for (int i = 0; i < v.addr_waits; i++) begin
        @(posedge clk); #1;
        chk("htrans_held_nonseq", 64'(bus.htrans), 64'd2);
      end
      bus.hready = 1'b1;
    end
    @(posedge clk); #1;
    chk("htrans_idle_in_data", 64'(bus.htrans), 64'd0);
    exp_hw = v.write ? v.wdata : 32'h0;
    bus.hrdata = v.hrdata;
    if (v.kind == 0) begin
      bus.hready = 1'b0;
      for (int i = 0; i <= v.data_waits; i++) begin
        chk("hwdata_stable", 64'(bus.hwdata), 64'(exp_hw));
`ifdef AHB_WSTRB_EN
        chk("hwstrb", 64'(bus.hwstrb), v.write ? 64'hA : 64'h0);
`endif
        if (i == v.data_waits) bus.hready = 1'b1;
        @(posedge clk); #1;
      end
      chk("resp_latency", 64'(bus.resp_valid), 64'd1);
    end else if (v.kind == 1) begin
      bus.hready = 1'b0;
      bus.hresp  = 1'b1;
      @(posedge clk); #1;
      chk("err_htrans_idle", 64'(bus.htrans), 64'd0);
      chk("err_no_early_resp", 64'(bus.resp_valid), 64'd0);
      bus.hready = 1'b1;
      @(posedge clk); #1;
      chk("err_resp", 64'(bus.resp_valid), 64'd1);
      bus.hresp = 1'b0;
    end else begin
      bus.hready = 1'b0;
      n = 0;
      for (int i = 0; i < 3 * c_timeout; i++) begin
        @(posedge clk); #1;
        n++;
        if (bus.resp_valid === 1'b1) break;
      end
      chk("timeout_cycles", 64'(n), 64'(c_timeout));
      bus.hready = 1'b1;
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    //           addr         wr    sz    wdata          hrdata         aw dw kind legal exp_rdata     slv   oth
    vecs[0]  = '{32'h40,  1'b0, 3'd2, 32'h0,         32'hCAFE_F00D, 0, 0, 0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[1]  = '{32'h10,  1'b1, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 0, 3, 0, 1'b1, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{32'h44,  1'b0, 3'd1, 32'h0,         32'h0000_BEEF, 2, 1, 0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0};
    vecs[3]  = '{32'h20,  1'b0, 3'd2, 32'h0,         32'h1111_2222, 0, 0, 1, 1'b1, 32'h0,         1'b1, 1'b0};
    vecs[4]  = '{32'h02,  1'b0, 3'd2, 32'h0,         32'h0,         0, 0, 0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[5]  = '{32'h00,  1'b0, 3'd3, 32'h0,         32'h0,         0, 0, 0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[6]  = '{32'h81,  1'b0, 3'd0, 32'h0,         32'h0000_0055, 0, 0, 0, 1'b1, 32'h0000_0055, 1'b0, 1'b0};
    vecs[7]  = '{32'h03,  1'b1, 3'd1, 32'h0,         32'h0,         0, 0, 0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[8]  = '{32'h30,  1'b0, 3'd2, 32'h0,         32'h7777_7777, 0, 0, 2, 1'b1, 32'h0,         1'b0, 1'b1};
    vecs[9]  = '{32'h34,  1'b0, 3'd2, 32'h0,         32'hA5A5_A5A5, 2, 0, 0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[10] = '{32'h50,  1'b1, 3'd2, 32'h0BAD_F00D, 32'h3333_3333, 0, 0, 1, 1'b1, 32'h0,         1'b1, 1'b0};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
`ifdef AHB_WSTRB_EN
    bus.req_strb  = '0;
`endif
    bus.hrdata = '0;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_htrans", 64'(bus.htrans), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Reset while a write is waiting in its data phase drops it silently
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_write = 1'b1;
    bus.req_size  = 3'd2;
    bus.req_wdata = 32'hFEED_FACE;
    bus.hready    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    bus.hready = 1'b0;
    chk("pre_rst_hwdata", 64'(bus.hwdata), 64'hFEED_FACE);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_htrans", 64'(bus.htrans), 64'd0);
    chk("mid_rst_haddr", 64'(bus.haddr), 64'd0);
    chk("mid_rst_hwrite", 64'(bus.hwrite), 64'd0);
    chk("mid_rst_hsize", 64'(bus.hsize), 64'd0);
    chk("mid_rst_hwdata", 64'(bus.hwdata), 64'd0);
    chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    bus.hready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_resp", 64'(bus.resp_valid), 64'd0);
    run_vec(vecs[0]);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
